bus_timer_dev: RTL and testbench

- Memory-mapped timer that sits on one device port of `bus`, at the device end of the host-to-device request path.
- It accepts single-cycle requests, serves register reads with one cycle of latency, and counts prescaled clock ticks.
- It compares the count against a programmable value and raises a level interrupt toward the core.

---
 rtl/bus_timer_dev.sv | 134 +++++++++++++
 tb/tb_bus_timer_dev.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bus_timer_dev.sv
// Memory-mapped prescaled timer with compare match, optional auto-reload and a
// level interrupt. Register reads return pre-update contents one cycle later.
module bus_timer_dev #(
  parameter int          DataWidth    = 32,
  parameter int          AddressWidth = 32,
  parameter logic [31:0] ResetCompare = 32'hFFFF_FFFF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    device_req_i,
  input  logic [AddressWidth-1:0] device_addr_i,
  input  logic                    device_we_i,
  input  logic [DataWidth-1:0]    device_wdata_i,
  output logic [DataWidth-1:0]    device_rdata_o,
  output logic                    timer_irq_o
);

  localparam logic [2:0] OffCtrl     = 3'd0;
  localparam logic [2:0] OffPrescale = 3'd1;
  localparam logic [2:0] OffCount    = 3'd2;
  localparam logic [2:0] OffCompare  = 3'd3;
  localparam logic [2:0] OffStatus   = 3'd4;

  logic [2:0]           ctrl_reg,     ctrl_next;
  logic [15:0]          prescale_reg, prescale_next;
  logic [DataWidth-1:0] count_reg,    count_next;
  logic [DataWidth-1:0] compare_reg,  compare_next;
  logic                 pend_reg,     pend_next;
  logic [15:0]          pcnt_reg,     pcnt_next;
  logic [DataWidth-1:0] rdata_reg,    rdata_next;
  logic                 irq_reg,      irq_next;

  logic [2:0] sel;
  logic       wr_en;
  logic       rd_en;
  logic       tick;
  logic       match;
  logic       unused_addr_bits;

  assign sel   = device_addr_i[4:2];
  assign wr_en = device_req_i & device_we_i;
  assign rd_en = device_req_i & ~device_we_i;

  // Only the register offset bits are decoded; the bus has already matched the base.
  assign unused_addr_bits = ^{device_addr_i[AddressWidth-1:5], device_addr_i[1:0]};

  assign tick  = ctrl_reg[0] && (pcnt_reg == prescale_reg);
  // A bus write to COUNT in a tick cycle suppresses the match entirely.
  assign match = tick && !(wr_en && sel == OffCount) && (count_reg == compare_reg);

  always_comb begin
    ctrl_next     = ctrl_reg;
    prescale_next = prescale_reg;
    count_next    = count_reg;
    compare_next  = compare_reg;
    pend_next     = pend_reg;
    pcnt_next     = pcnt_reg;
    rdata_next    = rdata_reg;

    if (!ctrl_reg[0]) begin
      pcnt_next = 16'd0;
    end else if (tick) begin
      pcnt_next = 16'd0;
    end else begin
      pcnt_next = pcnt_reg + 16'd1;
    end

    if (tick) begin
      if (match && ctrl_reg[2]) begin
        count_next = '0;
      end else begin
        count_next = count_reg + DataWidth'(1);
      end
    end

    if (wr_en) begin
      case (sel)
        OffCtrl:     ctrl_next = device_wdata_i[2:0];
        OffPrescale: begin
          prescale_next = device_wdata_i[15:0];
          pcnt_next     = 16'd0;
        end
        OffCount:    count_next   = device_wdata_i;
        OffCompare:  compare_next = device_wdata_i;
        OffStatus:   if (device_wdata_i[0]) pend_next = 1'b0;
        default:     ;
      endcase
    end

    // Set beats a same-cycle write-1-to-clear.
    if (match) begin
      pend_next = 1'b1;
    end

    if (rd_en) begin
      case (sel)
        OffCtrl:     rdata_next = {{(DataWidth-3){1'b0}}, ctrl_reg};
        OffPrescale: rdata_next = {{(DataWidth-16){1'b0}}, prescale_reg};
        OffCount:    rdata_next = count_reg;
        OffCompare:  rdata_next = compare_reg;
        OffStatus:   rdata_next = {{(DataWidth-1){1'b0}}, pend_reg};
        default:     rdata_next = '0;
      endcase
    end

    irq_next = pend_next & ctrl_next[1];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_reg     <= 3'd0;
      prescale_reg <= 16'd0;
      count_reg    <= '0;
      compare_reg  <= ResetCompare;
      pend_reg     <= 1'b0;
      pcnt_reg     <= 16'd0;
      rdata_reg    <= '0;
      irq_reg      <= 1'b0;
    end else begin
      ctrl_reg     <= ctrl_next;
      prescale_reg <= prescale_next;
      count_reg    <= count_next;
      compare_reg  <= compare_next;
      pend_reg     <= pend_next;
      pcnt_reg     <= pcnt_next;
      rdata_reg    <= rdata_next;
      irq_reg      <= irq_next;
    end
  end

  assign device_rdata_o = rdata_reg;
  assign timer_irq_o    = irq_reg;

endmodule

// File: tb/tb_bus_timer_dev.sv
// Directed bench for bus_timer_dev: register map, wrap, prescaled auto-reload,
// clear race, write/tick priority and asynchronous reset.
module tb_bus_timer_dev;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        device_req_i = 1'b0;
  logic [31:0] device_addr_i = '0;
  logic        device_we_i = 1'b0;
  logic [31:0] device_wdata_i = '0;
  logic [31:0] device_rdata_o;
  logic        timer_irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  bus_timer_dev dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .device_req_i   (device_req_i),
    .device_addr_i  (device_addr_i),
    .device_we_i    (device_we_i),
    .device_wdata_i (device_wdata_i),
    .device_rdata_o (device_rdata_o),
    .timer_irq_o    (timer_irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Each access occupies one request cycle; tasks return #1 after its edge.
  task automatic bus_write(input logic [2:0] off, input logic [31:0] data);
    @(negedge clk_i);
    device_req_i   = 1'b1;
    device_we_i    = 1'b1;
    device_addr_i  = {27'd0, off, 2'b00};
    device_wdata_i = data;
    @(posedge clk_i);
    #1;
    device_req_i = 1'b0;
    device_we_i  = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [2:0] off, input logic [31:0] exp);
    @(negedge clk_i);
    device_req_i  = 1'b1;
    device_we_i   = 1'b0;
    device_addr_i = {27'd0, off, 2'b00};
    @(posedge clk_i);
    #1;
    device_req_i = 1'b0;
    check_eq(tag, device_rdata_o, exp);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  logic [31:0] reset_map [8];

  initial begin
    reset_map = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};

    #2;
    check_eq("reset rdata", device_rdata_o, 32'h0);
    check_eq("reset irq", {31'd0, timer_irq_o}, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < 8; i++) begin
      read_check($sformatf("reset map off%0d", i), 3'(i), reset_map[i]);
      check_eq($sformatf("reset map irq%0d", i), {31'd0, timer_irq_o}, 32'h0);
    end

    // Free run at PRESCALE = 0 through the 32-bit wrap.
    bus_write(3'd2, 32'hFFFF_FFFE);
    bus_write(3'd0, 32'd1);
    read_check("wrap c0", 3'd2, 32'hFFFF_FFFE);
    read_check("wrap c1", 3'd2, 32'hFFFF_FFFF);
    read_check("wrap c2", 3'd2, 32'h0000_0000);
    read_check("wrap c3", 3'd2, 32'h0000_0001);
    read_check("wrap c4", 3'd2, 32'h0000_0002);
    // COUNT passed the reset COMPARE value during the wrap.
    read_check("wrap pend", 3'd4, 32'h1);
    check_eq("wrap irq", {31'd0, timer_irq_o}, 32'h0);

    // Prescaled auto-reload: ticks every 4 cycles, match at COUNT=5.
    bus_write(3'd0, 32'd0);
    bus_write(3'd4, 32'd1);
    bus_write(3'd2, 32'd0);
    bus_write(3'd1, 32'd3);
    bus_write(3'd3, 32'd5);
    bus_write(3'd0, 32'd7);
    begin
      int early_irq = 0;
      for (int i = 1; i <= 23; i++) begin
        wait_edges(1);
        early_irq += int'(timer_irq_o);
      end
      check_eq("ar irq before match", 32'(early_irq), 32'h0);
    end
    wait_edges(1);
    check_eq("ar irq at match", {31'd0, timer_irq_o}, 32'h1);
    read_check("ar pend", 3'd4, 32'h1);
    read_check("ar count reloaded", 3'd2, 32'h0);
    wait_edges(21);
    check_eq("ar irq held", {31'd0, timer_irq_o}, 32'h1);

    // Clear race: write-1-to-clear in the match cycle loses, one cycle later wins.
    bus_write(3'd4, 32'd1);
    check_eq("race clear in match", {31'd0, timer_irq_o}, 32'h1);
    bus_write(3'd4, 32'd1);
    check_eq("race clear after", {31'd0, timer_irq_o}, 32'h0);
    read_check("race pend cleared", 3'd4, 32'h0);
    wait_edges(21);
    check_eq("ar irq before 2nd", {31'd0, timer_irq_o}, 32'h0);
    wait_edges(1);
    check_eq("ar irq 24 later", {31'd0, timer_irq_o}, 32'h1);

    // Write versus tick at PRESCALE = 0.
    bus_write(3'd0, 32'd1);
    check_eq("ie off irq", {31'd0, timer_irq_o}, 32'h0);
    bus_write(3'd1, 32'd0);
    bus_write(3'd2, 32'd100);
    wait_edges(1);
    read_check("write wins tick", 3'd2, 32'd101);
    bus_write(3'd0, 32'd0);
    check_eq("rdata held on write", device_rdata_o, 32'd101);
    wait_edges(10);
    check_eq("rdata held idle", device_rdata_o, 32'd101);
    read_check("en0 hold", 3'd2, 32'd103);

    // Asynchronous reset mid-operation with PEND set.
    bus_write(3'd0, 32'd3);
    check_eq("pre reset irq", {31'd0, timer_irq_o}, 32'h1);
    #3;
    rst_i = 1'b0;
    #1;
    check_eq("async rst irq", {31'd0, timer_irq_o}, 32'h0);
    check_eq("async rst rdata", device_rdata_o, 32'h0);
    wait_edges(2);
    @(negedge clk_i);
    rst_i = 1'b1;
    read_check("post rst ctrl", 3'd0, 32'h0);
    read_check("post rst count", 3'd2, 32'h0);
    read_check("post rst status", 3'd4, 32'h0);
    read_check("post rst compare", 3'd3, 32'hFFFF_FFFF);
    check_eq("post rst irq", {31'd0, timer_irq_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
